reg_file_sb: RTL and testbench

- Parametrised successor of the pipeline register file: NUM_REGS x DATA_W general registers, two combinational read ports, one writeback port.
- Adds optional write-through bypass and a per-register pending-write scoreboard.
- The scoreboard counts in-flight writes issued in ID and retired in WB. It drives per-source hazard flags to the hazard unit.
- Sits between ID (reads, issue) and WB (writes); the PC is not held here.

---
 rtl/reg_file_sb_if.sv | 32 +++
 rtl/reg_file_sb.sv | 112 +++++++++++
 tb/tb_reg_file_sb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus between ID/WB and reg_file_sb.
// Carries two read ports, the writeback port, the issue port, per-source hazard
// flags and the sticky scoreboard error flag.
// master: ID/WB side (drives addresses, writeback and issue; samples data and flags).
// slave : the register file itself.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              wb_en;
    logic [ADDR_W-1:0] dest_wb;
    logic [DATA_W-1:0] result_wb;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dest;
    logic              hazard1;
    logic              hazard2;
    logic              sb_err;

    modport master (
        output src1, src2, wb_en, dest_wb, result_wb, issue_en, issue_dest,
        input  reg1, reg2, hazard1, hazard2, sb_err
    );

    modport slave (
        input  src1, src2, wb_en, dest_wb, result_wb, issue_en, issue_dest,
        output reg1, reg2, hazard1, hazard2, sb_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with optional write-through bypass and per-register
// pending-write scoreboard.
// Ports:
//   clk  - clock, state updates on rising edge
//   rst  - asynchronous active-low reset
//   bus  - reg_file_sb_if.slave: src1/src2 -> reg1/reg2 (combinational reads),
//          wb_en/dest_wb/result_wb (writeback + retire), issue_en/issue_dest
//          (issue), hazard1/hazard2 (combinational), sb_err (sticky, registered)
module reg_file_sb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_REGS   = 15,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned PEND_W     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_INDEX = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [PEND_W-1:0]   r_pend [NUM_REGS];
    logic                r_sb_err;

    logic [NUM_REGS-1:0] w_iss;
    logic [NUM_REGS-1:0] w_ret;
    logic [PEND_W-1:0]   w_pend_nxt [NUM_REGS];
    logic                w_err_set;
    logic [ADDR_W-1:0]   w_src [2];
    logic [DATA_W-1:0]   w_rd  [2];
    logic                w_hz  [2];

    // One-hot issue/retire decode; out-of-range addresses match nothing.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_iss[r] = bus.issue_en && (bus.issue_dest == ADDR_W'(r));
            w_ret[r] = bus.wb_en    && (bus.dest_wb    == ADDR_W'(r));
        end
    end

    // Pending counter next state; saturating issue and underflowing retire flag an error.
    always_comb begin
        w_err_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_pend_nxt[r] = r_pend[r];
            if (w_iss[r] && !w_ret[r]) begin
                if (r_pend[r] == PEND_W'(PEND_MAX)) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pend_nxt[r] = r_pend[r] + PEND_W'(1);
                end
            end else if (w_ret[r] && !w_iss[r]) begin
                if (r_pend[r] == '0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pend_nxt[r] = r_pend[r] - PEND_W'(1);
                end
            end
        end
    end

    assign w_src[0] = bus.src1;
    assign w_src[1] = bus.src2;

    // Read ports; bypass is suppressed under reset so reads show reset contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            w_hz[p] = 1'b0;
            if (32'(w_src[p]) < NUM_REGS) begin
                w_rd[p] = r_regs[w_src[p]];
                w_hz[p] = (r_pend[w_src[p]] != '0);
                if ((BYPASS != 0) && rst && bus.wb_en && (bus.dest_wb == w_src[p])) begin
                    w_rd[p] = bus.result_wb;
                    // Last outstanding write is being forwarded: value is final.
                    if (r_pend[w_src[p]] == PEND_W'(1)) begin
                        w_hz[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Register array, pending counters and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= (INIT_INDEX != 0) ? DATA_W'(r) : {DATA_W{1'b0}};
                r_pend[r] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_ret[r]) begin
                    r_regs[r] <= bus.result_wb;
                end
                r_pend[r] <= w_pend_nxt[r];
            end
            if (w_err_set) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign bus.reg1    = w_rd[0];
    assign bus.reg2    = w_rd[1];
    assign bus.hazard1 = w_hz[0];
    assign bus.hazard2 = w_hz[1];
    assign bus.sb_err  = r_sb_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus and
// are compared every cycle against an array/counter model, plus literal checks.
module tb_reg_file_sb;
    localparam int unsigned DW   = 32;
    localparam int unsigned NR   = 15;
    localparam int unsigned AW   = 4;
    localparam int          PMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] src1 = '0, src2 = '0, dest_wb = '0, issue_dest = '0;
    logic [DW-1:0] result_wb = '0;
    logic          wb_en = 1'b0, issue_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

    assign ifa.src1 = src1;        assign ifb.src1 = src1;
    assign ifa.src2 = src2;        assign ifb.src2 = src2;
    assign ifa.wb_en = wb_en;      assign ifb.wb_en = wb_en;
    assign ifa.dest_wb = dest_wb;  assign ifb.dest_wb = dest_wb;
    assign ifa.result_wb = result_wb;   assign ifb.result_wb = result_wb;
    assign ifa.issue_en = issue_en;     assign ifb.issue_en = issue_en;
    assign ifa.issue_dest = issue_dest; assign ifb.issue_dest = issue_dest;

    reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PEND_W(2), .BYPASS(1), .INIT_INDEX(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PEND_W(2), .BYPASS(0), .INIT_INDEX(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0] m_regs [NR];
    int            m_pend [NR];
    bit            m_err;

    task automatic m_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_regs[i] = DW'(i);
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_step();
        bit iss;
        bit ret;
        iss = issue_en && (int'(issue_dest) < int'(NR));
        ret = wb_en && (int'(dest_wb) < int'(NR));
        if (ret) m_regs[int'(dest_wb)] = result_wb;
        if (!(iss && ret && issue_dest == dest_wb)) begin
            if (iss) begin
                if (m_pend[int'(issue_dest)] == PMAX) m_err = 1'b1;
                else m_pend[int'(issue_dest)]++;
            end
            if (ret) begin
                if (m_pend[int'(dest_wb)] == 0) m_err = 1'b1;
                else m_pend[int'(dest_wb)]--;
            end
        end
    endtask

    function automatic logic [DW-1:0] e_rd(bit byp, logic [AW-1:0] s);
        if (int'(s) >= int'(NR)) return '0;
        if (byp && rst && wb_en && dest_wb == s) return result_wb;
        return m_regs[int'(s)];
    endfunction

    function automatic logic e_hz(bit byp, logic [AW-1:0] s);
        if (int'(s) >= int'(NR)) return 1'b0;
        if (m_pend[int'(s)] == 0) return 1'b0;
        if (byp && rst && wb_en && dest_wb == s && m_pend[int'(s)] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else m_step();
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("a.reg1", ifa.reg1, e_rd(1'b1, src1));
        chk("a.reg2", ifa.reg2, e_rd(1'b1, src2));
        chk("a.hz1", 32'(ifa.hazard1), 32'(e_hz(1'b1, src1)));
        chk("a.hz2", 32'(ifa.hazard2), 32'(e_hz(1'b1, src2)));
        chk("a.err", 32'(ifa.sb_err), 32'(m_err));
        chk("b.reg1", ifb.reg1, e_rd(1'b0, src1));
        chk("b.reg2", ifb.reg2, e_rd(1'b0, src2));
        chk("b.hz1", 32'(ifb.hazard1), 32'(e_hz(1'b0, src1)));
        chk("b.hz2", 32'(ifb.hazard2), 32'(e_hz(1'b0, src2)));
        chk("b.err", 32'(ifb.sb_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wb_en = 1'b0;
        issue_en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(0, 4));
    endfunction

    initial begin
        // Reset then read
        #1 rst = 1'b0;
        src1 = 4'd3; src2 = 4'd14;
        #1;
        chk("rst.reg1", ifa.reg1, 32'd3);
        chk("rst.reg2", ifa.reg2, 32'd14);
        chk("rst.hz1", 32'(ifa.hazard1), 32'd0);
        chk("rst.err", 32'(ifa.sb_err), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("r.reg1", ifa.reg1, 32'd3);
        chk("r.reg2", ifb.reg2, 32'd14);
        src1 = 4'd15;
        #1;
        chk("r.oob", ifa.reg1, 32'd0);

        // Write and bypass
        wb_en = 1'b1; dest_wb = 4'd5; result_wb = 32'hDEADBEEF; src1 = 4'd5;
        #1;
        chk("byp.a", ifa.reg1, 32'hDEADBEEF);
        chk("byp.b", ifb.reg1, 32'd5);
        tick();
        wb_en = 1'b0;
        #1;
        chk("wr.a", ifa.reg1, 32'hDEADBEEF);
        chk("wr.b", ifb.reg1, 32'hDEADBEEF);
        do_reset();

        // Scoreboard on R2
        issue_en = 1'b1; issue_dest = 4'd2;
        tick(); tick();
        issue_en = 1'b0; src1 = 4'd2;
        #1;
        chk("sb.p2", 32'(ifa.hazard1), 32'd1);
        wb_en = 1'b1; dest_wb = 4'd2; result_wb = 32'h1111;
        #1;
        chk("sb.ret1", 32'(ifa.hazard1), 32'd1);
        tick();
        result_wb = 32'h2222;
        #1;
        chk("sb.ret2.hz", 32'(ifa.hazard1), 32'd0);
        chk("sb.ret2.rd", ifa.reg1, 32'h2222);
        chk("sb.ret2.bhz", 32'(ifb.hazard1), 32'd1);
        chk("sb.ret2.brd", ifb.reg1, 32'h1111);
        tick();
        wb_en = 1'b0;
        #1;
        chk("sb.done.hz", 32'(ifa.hazard1), 32'd0);
        chk("sb.done.err", 32'(ifa.sb_err), 32'd0);

        // Simultaneous issue and retire on R7, then issue R1 / retire R4
        issue_en = 1'b1; issue_dest = 4'd7;
        tick();
        wb_en = 1'b1; dest_wb = 4'd7; result_wb = 32'h77; src1 = 4'd7;
        #1;
        chk("sim7.a", 32'(ifa.hazard1), 32'd0);
        chk("sim7.b", 32'(ifb.hazard1), 32'd1);
        tick();
        wb_en = 1'b0; issue_en = 1'b0;
        #1;
        chk("sim7.after", 32'(ifa.hazard1), 32'd1);
        chk("sim7.rd", ifa.reg1, 32'h77);
        issue_en = 1'b1; issue_dest = 4'd4;
        tick();
        issue_dest = 4'd1; wb_en = 1'b1; dest_wb = 4'd4; result_wb = 32'h44;
        tick();
        issue_en = 1'b0; wb_en = 1'b0; src1 = 4'd1; src2 = 4'd4;
        #1;
        chk("ind.hz1", 32'(ifa.hazard1), 32'd1);
        chk("ind.hz2", 32'(ifa.hazard2), 32'd0);
        chk("ind.rd2", ifa.reg2, 32'h44);
        chk("ind.err", 32'(ifa.sb_err), 32'd0);

        // Saturation on R0
        do_reset();
        issue_en = 1'b1; issue_dest = 4'd0;
        repeat (4) tick();
        issue_en = 1'b0; src1 = 4'd0;
        #1;
        chk("sat.err", 32'(ifa.sb_err), 32'd1);
        chk("sat.hz", 32'(ifa.hazard1), 32'd1);
        wb_en = 1'b1; dest_wb = 4'd0; result_wb = 32'h5;
        repeat (3) tick();
        wb_en = 1'b0;
        #1;
        chk("sat.drain", 32'(ifb.hazard1), 32'd0);

        // Underflow on R9
        do_reset();
        wb_en = 1'b1; dest_wb = 4'd9; result_wb = 32'h99;
        tick();
        wb_en = 1'b0; src1 = 4'd9;
        #1;
        chk("uf.rd", ifb.reg1, 32'h99);
        chk("uf.err", 32'(ifa.sb_err), 32'd1);

        // Asynchronous reset mid-traffic
        do_reset();
        issue_en = 1'b1; issue_dest = 4'd3;
        repeat (2) tick();
        issue_en = 1'b0; wb_en = 1'b1; dest_wb = 4'd3; result_wb = 32'hABC;
        src1 = 4'd3; src2 = 4'd3;
        #1;
        chk("ar.pre", 32'(ifa.hazard1), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar.hz1", 32'(ifa.hazard1), 32'd0);
        chk("ar.hz2", 32'(ifa.hazard2), 32'd0);
        chk("ar.rd", ifa.reg1, 32'd3);
        chk("ar.rdb", ifb.reg1, 32'd3);
        chk("ar.err", 32'(ifa.sb_err), 32'd0);
        wb_en = 1'b0;
        #2 rst = 1'b1;
        tick();

        // Randomized traffic with occasional resets
        do_reset();
        repeat (3000) begin
            tick();
            rst        = ($urandom_range(0, 99) != 0);
            src1       = AW'($urandom_range(0, 15));
            src2       = rnd_addr();
            wb_en      = ($urandom_range(0, 1) == 1);
            dest_wb    = rnd_addr();
            result_wb  = $urandom;
            issue_en   = ($urandom_range(0, 1) == 1);
            issue_dest = rnd_addr();
        end
        tick();
        do_reset();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
